voxel_mem_arb: RTL and testbench

- Arbitrates the single-port voxel BRAM (64-bit word, 18-bit word address) among three requesters:
  - render-core reads
  - DMA-engine writes
  - CSR debug writes (dbg_we_pulse / dbg_addr / dbg_wdata)
- Sits between the AXI-Lite CSR block, the DMA engine and the raycaster.
- Fixed priority with a per-requester starvation override.
- Posted debug writes go through a one-entry holding buffer.

---
 rtl/voxel_mem_pkg.sv | 35 +++
 rtl/voxel_mem_arb_rd_pipe.sv | 24 ++
 rtl/voxel_mem_arb.sv | 156 +++++++++++++++
 tb/tb_voxel_mem_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_mem_pkg.sv
// Shared widths, requester encoding and BRAM command type for the voxel memory arbiter.
package voxel_mem_pkg;

  localparam int VOX_ADDR_W = 18;
  localparam int VOX_DATA_W = 64;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_RD   = 2'd1,
    REQ_DMA  = 2'd2,
    REQ_DBG  = 2'd3
  } vox_req_e;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [VOX_ADDR_W-1:0] addr;
    logic [VOX_DATA_W-1:0] wdata;
  } vox_cmd_t;

  // A starved writer outranks the render core; otherwise reads come first.
  function automatic vox_req_e vox_pick(input logic rd_req, input logic dma_req,
                                        input logic dbg_req, input logic dma_hot,
                                        input logic dbg_hot);
    vox_req_e pick;
    pick = REQ_NONE;
    if (dma_hot)      pick = REQ_DMA;
    else if (dbg_hot) pick = REQ_DBG;
    else if (rd_req)  pick = REQ_RD;
    else if (dma_req) pick = REQ_DMA;
    else if (dbg_req) pick = REQ_DBG;
    return pick;
  endfunction

endpackage

// File: rtl/voxel_mem_arb_rd_pipe.sv
// Valid-only shift pipe that marks when BRAM read data for an accepted read is on mem_rdata.
module voxel_rd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] pipe;

  // Reset flushes every in-flight read so none of them produce a return pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | DEPTH'(in_valid);
    end
  end

  assign out_valid = pipe[DEPTH-1];

endmodule

// File: rtl/voxel_mem_arb.sv
// Single-port voxel BRAM arbiter: render reads, DMA writes and posted CSR debug writes.
module voxel_mem_arb
  import voxel_mem_pkg::*;
#(
  parameter int ADDR_W     = VOX_ADDR_W,
  parameter int DATA_W     = VOX_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  input  logic              dma_wvalid,
  output logic              dma_wready,
  input  logic [ADDR_W-1:0] dma_waddr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dbg_we_pulse,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_pending,
  output logic              dbg_overflow,
  input  logic              dbg_ovf_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [SW-1:0]     dma_starve;
  logic [SW-1:0]     dbg_starve;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [DATA_W-1:0] dbg_wdata_q;
  logic              dma_hot;
  logic              dbg_hot;
  logic              rd_gnt;
  logic              dma_gnt;
  logic              dbg_gnt;
  vox_req_e          gnt;
  vox_cmd_t          cmd_d;
  vox_cmd_t          cmd_q;

  // No grant is issued while in reset, so a waiting DMA write stays unacknowledged.
  always_comb begin
    dma_hot = dma_wvalid && (dma_starve == LIM);
    dbg_hot = dbg_pending && (dbg_starve == LIM);
    gnt     = REQ_NONE;
    if (!rst) begin
      gnt = vox_pick(rd_valid, dma_wvalid, dbg_pending, dma_hot, dbg_hot);
    end
  end

  assign rd_gnt     = (gnt == REQ_RD);
  assign dma_gnt    = (gnt == REQ_DMA);
  assign dbg_gnt    = (gnt == REQ_DBG);
  assign rd_ready   = rd_gnt;
  assign dma_wready = dma_gnt;

  always_comb begin
    cmd_d = '0;
    case (gnt)
      REQ_RD: begin
        cmd_d.en   = 1'b1;
        cmd_d.addr = VOX_ADDR_W'(rd_addr);
      end
      REQ_DMA: begin
        cmd_d.en    = 1'b1;
        cmd_d.we    = 1'b1;
        cmd_d.addr  = VOX_ADDR_W'(dma_waddr);
        cmd_d.wdata = VOX_DATA_W'(dma_wdata);
      end
      REQ_DBG: begin
        cmd_d.en    = 1'b1;
        cmd_d.we    = 1'b1;
        cmd_d.addr  = VOX_ADDR_W'(dbg_addr_q);
        cmd_d.wdata = VOX_DATA_W'(dbg_wdata_q);
      end
      default: cmd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  assign mem_en    = cmd_q.en;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = ADDR_W'(cmd_q.addr);
  assign mem_wdata = DATA_W'(cmd_q.wdata);

  // Counters only accumulate consecutive lost cycles of a still-waiting writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_starve <= '0;
      dbg_starve <= '0;
    end else begin
      if (!dma_wvalid || dma_gnt) begin
        dma_starve <= '0;
      end else if (dma_starve != LIM) begin
        dma_starve <= dma_starve + 1'b1;
      end
      if (!dbg_pending || dbg_gnt) begin
        dbg_starve <= '0;
      end else if (dbg_starve != LIM) begin
        dbg_starve <= dbg_starve + 1'b1;
      end
    end
  end

  // A pulse is accepted whenever the slot is free by the end of this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_pending  <= 1'b0;
      dbg_overflow <= 1'b0;
      dbg_addr_q   <= '0;
      dbg_wdata_q  <= '0;
    end else begin
      if (dbg_we_pulse && (!dbg_pending || dbg_gnt)) begin
        dbg_pending <= 1'b1;
        dbg_addr_q  <= dbg_addr;
        dbg_wdata_q <= dbg_wdata;
      end else if (dbg_gnt) begin
        dbg_pending <= 1'b0;
      end
      if (dbg_we_pulse && dbg_pending && !dbg_gnt) begin
        dbg_overflow <= 1'b1;
      end else if (dbg_ovf_clr) begin
        dbg_overflow <= 1'b0;
      end
    end
  end

  // One extra stage covers the registered BRAM command ahead of the BRAM latency.
  voxel_rd_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_gnt),
    .out_valid(rd_rvalid)
  );

  assign rd_rdata = rd_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_voxel_mem_arb.sv
// Directed self-checking bench for voxel_mem_arb with a small BRAM model (RD_LAT = 1).
module tb_voxel_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid;
  logic        rd_ready;
  logic [17:0] rd_addr;
  logic        rd_rvalid;
  logic [63:0] rd_rdata;
  logic        dma_wvalid;
  logic        dma_wready;
  logic [17:0] dma_waddr;
  logic [63:0] dma_wdata;
  logic        dbg_we_pulse;
  logic [17:0] dbg_addr;
  logic [63:0] dbg_wdata;
  logic        dbg_pending;
  logic        dbg_overflow;
  logic        dbg_ovf_clr;
  logic        mem_en;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] bram [0:255];
  int          tests;
  int          failed;

  always #5 clk = ~clk;

  voxel_mem_arb #(
    .ADDR_W(18), .DATA_W(64), .RD_LAT(1), .STARVE_LIM(16)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
    .dma_waddr(dma_waddr), .dma_wdata(dma_wdata),
    .dbg_we_pulse(dbg_we_pulse), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_pending(dbg_pending), .dbg_overflow(dbg_overflow), .dbg_ovf_clr(dbg_ovf_clr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // One-cycle-latency BRAM, indexed by the low address byte.
  always @(posedge clk) begin
    if (rst) begin
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr[7:0]];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [17:0] ra, input logic dv,
                               input logic [17:0] da, input logic [63:0] dd);
    rd_valid   = rv;
    rd_addr    = ra;
    dma_wvalid = dv;
    dma_waddr  = da;
    dma_wdata  = dd;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 64'h0);
    dbg_we_pulse = 1'b0;
    dbg_addr     = 18'h0;
    dbg_wdata    = 64'h0;
    dbg_ovf_clr  = 1'b0;
    tick();
    tick();
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_rvalid", rd_rvalid, 0);
    checkOutput("rst_rdata", rd_rdata, 0);
    checkOutput("rst_pending", dbg_pending, 0);
    checkOutput("rst_overflow", dbg_overflow, 0);
    rst = 1'b0;

    // Preload address 0x10 through a DMA write.
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h00010, 64'hDEAD_BEEF_0000_0001);
    #1 checkOutput("pre_wready", dma_wready, 1);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 64'h0);
    checkOutput("pre_mem_we", mem_we, 1);
    checkOutput("pre_mem_addr", mem_addr, 18'h00010);
    checkOutput("pre_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0001);
    tick();

    // Read latency.
    applyStimulus(1'b1, 18'h00010, 1'b0, 18'h0, 64'h0);
    #1 checkOutput("lat_rd_ready", rd_ready, 1);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 64'h0);
    checkOutput("lat_mem_en", mem_en, 1);
    checkOutput("lat_mem_we", mem_we, 0);
    checkOutput("lat_mem_addr", mem_addr, 18'h00010);
    checkOutput("lat_rvalid_c1", rd_rvalid, 0);
    tick();
    checkOutput("lat_rvalid_c2", rd_rvalid, 1);
    checkOutput("lat_rdata_c2", rd_rdata, 64'hDEAD_BEEF_0000_0001);
    tick();
    checkOutput("lat_rvalid_c3", rd_rvalid, 0);

    // Same-cycle contention: R, then D, then buffered G.
    dbg_we_pulse = 1'b1;
    dbg_addr     = 18'h00030;
    dbg_wdata    = 64'h2222;
    tick();
    dbg_we_pulse = 1'b0;
    applyStimulus(1'b1, 18'h00040, 1'b1, 18'h00020, 64'h1111);
    #1 checkOutput("con_pending", dbg_pending, 1);
    checkOutput("con_rd_ready", rd_ready, 1);
    checkOutput("con_wready_c0", dma_wready, 0);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b1, 18'h00020, 64'h1111);
    #1 checkOutput("con_wready_c1", dma_wready, 1);
    checkOutput("con_en_c1", mem_en, 1);
    checkOutput("con_we_c1", mem_we, 0);
    tick();
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 64'h0);
    checkOutput("con_en_c2", mem_en, 1);
    checkOutput("con_we_c2", mem_we, 1);
    checkOutput("con_addr_c2", mem_addr, 18'h00020);
    checkOutput("con_wdata_c2", mem_wdata, 64'h1111);
    tick();
    checkOutput("con_en_c3", mem_en, 1);
    checkOutput("con_we_c3", mem_we, 1);
    checkOutput("con_addr_c3", mem_addr, 18'h00030);
    checkOutput("con_wdata_c3", mem_wdata, 64'h2222);
    checkOutput("con_pending_c3", dbg_pending, 0);
    tick();
    checkOutput("con_en_c4", mem_en, 0);

    // Starvation: DMA preempts a continuous render stream at cycle 16.
    applyStimulus(1'b1, 18'h00050, 1'b1, 18'h00060, 64'h3333);
    #1 checkOutput("stv_wready_c0", dma_wready, 0);
    for (int i = 1; i <= 15; i++) tick();
    checkOutput("stv_wready_c15", dma_wready, 0);
    checkOutput("stv_count_c15", dut.dma_starve, 15);
    tick();
    checkOutput("stv_wready_c16", dma_wready, 1);
    checkOutput("stv_rd_ready_c16", rd_ready, 0);
    tick();
    applyStimulus(1'b1, 18'h00050, 1'b0, 18'h0, 64'h0);
    #1 checkOutput("stv_rd_ready_c17", rd_ready, 1);
    checkOutput("stv_count_c17", dut.dma_starve, 0);
    checkOutput("stv_mem_addr_c17", mem_addr, 18'h00060);
    checkOutput("stv_mem_we_c17", mem_we, 1);

    // Debug overflow: B dropped while A waits behind reads.
    dbg_we_pulse = 1'b1;
    dbg_addr     = 18'h3FFFF;
    dbg_wdata    = 64'hA5A5;
    tick();
    dbg_addr  = 18'h00011;
    dbg_wdata = 64'hBBBB;
    checkOutput("ovf_pending_c1", dbg_pending, 1);
    checkOutput("ovf_flag_c1", dbg_overflow, 0);
    tick();
    dbg_we_pulse = 1'b0;
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 64'h0);
    checkOutput("ovf_flag_c2", dbg_overflow, 1);
    checkOutput("ovf_pending_c2", dbg_pending, 1);
    tick();
    checkOutput("ovf_addr_c3", mem_addr, 18'h3FFFF);
    checkOutput("ovf_wdata_c3", mem_wdata, 64'hA5A5);
    checkOutput("ovf_we_c3", mem_we, 1);
    checkOutput("ovf_pending_c3", dbg_pending, 0);
    dbg_ovf_clr = 1'b1;
    tick();
    dbg_ovf_clr = 1'b0;
    checkOutput("ovf_clr", dbg_overflow, 0);
    checkOutput("ovf_b_not_written", mem_en, 0);

    // Free and refill in the same cycle.
    dbg_we_pulse = 1'b1;
    dbg_addr     = 18'h00012;
    dbg_wdata    = 64'h5A5A;
    tick();
    dbg_addr  = 18'h00022;
    dbg_wdata = 64'hCCCC;
    tick();
    dbg_we_pulse = 1'b0;
    checkOutput("ref_addr_a", mem_addr, 18'h00012);
    checkOutput("ref_wdata_a", mem_wdata, 64'h5A5A);
    checkOutput("ref_pending", dbg_pending, 1);
    checkOutput("ref_overflow", dbg_overflow, 0);
    tick();
    checkOutput("ref_addr_c", mem_addr, 18'h00022);
    checkOutput("ref_wdata_c", mem_wdata, 64'hCCCC);
    checkOutput("ref_pending_done", dbg_pending, 0);
    tick();

    // Reset one cycle after a read handshake.
    applyStimulus(1'b1, 18'h00010, 1'b1, 18'h00060, 64'h4444);
    dbg_we_pulse = 1'b1;
    dbg_addr     = 18'h00033;
    dbg_wdata    = 64'h7777;
    #1 checkOutput("mrr_rd_ready", rd_ready, 1);
    tick();
    dbg_we_pulse = 1'b0;
    rd_valid = 1'b0;
    rst = 1'b1;
    #1 checkOutput("mrr_wready_in_rst", dma_wready, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 18'h0, 1'b0, 18'h0, 64'h0);
    checkOutput("mrr_rvalid_c2", rd_rvalid, 0);
    checkOutput("mrr_mem_en", mem_en, 0);
    checkOutput("mrr_pending", dbg_pending, 0);
    checkOutput("mrr_dma_starve", dut.dma_starve, 0);
    checkOutput("mrr_dbg_starve", dut.dbg_starve, 0);
    tick();
    checkOutput("mrr_rvalid_c3", rd_rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
